iob_wishbone2iob: RTL and testbench
===================================

// Module: iob_wishbone2iob
// PURPOSE
//  Wishbone classic (B4, non-pipelined) slave to IOb native master bridge. Lets a Wishbone
//  master (e.g. ethmac DMA) reach IOb peripherals/memory. Registers each Wishbone request,
//  holds it on IOb until ready_i, returns a one-cycle wb_ack_o with registered read data.
//  wb_err_o on a response timeout.
// PARAMETERS
//  ADDR_W     32  address width, both sides
//  DATA_W     32  data width, both sides; DATA_W/8 byte lanes
//  TIMEOUT    255 max cycles valid_o waits for ready_i; 0 = no timeout (wait forever)
//  TIMEOUT_W  8   width of timeout counter; must hold TIMEOUT
// PORTS
//  clk_i        in   1         clock, all logic on rising edge
//  rst_i        in   1         reset, synchronous, active-high
//  wb_addr_i    in   ADDR_W    Wishbone address
//  wb_data_i    in   DATA_W    Wishbone write data
//  wb_select_i  in   DATA_W/8  Wishbone byte select
//  wb_we_i      in   1         Wishbone write enable
//  wb_cyc_i     in   1         Wishbone cycle
//  wb_stb_i     in   1         Wishbone strobe
//  wb_data_o    out  DATA_W    Wishbone read data, valid with wb_ack_o
//  wb_ack_o     out  1         Wishbone acknowledge, 1-cycle pulse
//  wb_err_o     out  1         Wishbone error (timeout), 1-cycle pulse
//  valid_o      out  1         IOb request valid
//  address_o    out  ADDR_W    IOb address
//  wdata_o      out  DATA_W    IOb write data
//  wstrb_o      out  DATA_W/8  IOb write strobe; all-zero = read
//  rdata_i      in   DATA_W    IOb read data, valid with ready_i
//  ready_i      in   1         IOb ready/response
// BEHAVIOUR
//  All outputs registered. Reset: state IDLE, valid_o/wb_ack_o/wb_err_o=0, address_o,
//   wdata_o, wstrb_o, wb_data_o = 0, timeout counter = 0. Reset mid-transfer drops it silently.
//  FSM states IDLE, REQ, ACK, ERR, DRAIN:
//  IDLE: on cyc_i&stb_i: latch addr->address_o, data->wdata_o,
//   wstrb_o = we_i ? select_i : 0; valid_o<=1; counter<=0; -> REQ.
//  REQ: valid_o and request fields held stable until ready_i sampled 1.
//   ready_i=1: valid_o<=0; wb_data_o<=rdata_i (reads; holds old value on writes);
//    cyc_i&stb_i still 1 -> ACK (wb_ack_o<=1); cyc_i=0 -> IDLE, no ack.
//   ready_i=0, cyc_i=0 (master abort): -> DRAIN (IOb txn cannot be abandoned).
//   ready_i=0, TIMEOUT!=0, counter==TIMEOUT-1: valid_o<=0; wb_err_o<=1; -> ERR.
//   else counter+1. Counter saturates; never wraps.
//  DRAIN: valid_o held until ready_i; then valid_o<=0, -> IDLE; no ack/err; timeout applies
//   (expiry -> IDLE, no err).
//  ACK / ERR: wb_ack_o / wb_err_o high exactly 1 cycle, then cleared; -> IDLE.
//   New request not sampled in ACK/ERR (stb_i still up for the acked txn); sampled
//   in IDLE next cycle. wb_ack_o and wb_err_o never high together.
//  Latency: stb seen cycle 0 -> valid_o cycle 1; ready_i in cycle k (k>=1) -> wb_ack_o
//   cycle k+1. Minimum 2-cycle ack latency; 3-cycle issue-to-issue for back-to-back.
//  ready_i while valid_o=0 (IDLE/ACK/ERR, late after timeout) is ignored.
//  valid_o never reasserts in the cycle after it drops (always passes through ACK/ERR/IDLE).
// TESTING
//  Write: addr=0x10, data=0xDEADBEEF, sel=0xF, we=1, ready_i 2 cycles after valid_o
//   -> wstrb_o=0xF, fields stable while valid_o, one wb_ack_o pulse, valid_o low at ack.
//  Read: addr=0x20, we=0, sel=0x3, ready_i with rdata_i=0xCAFEF00D -> wstrb_o=0,
//   wb_data_o=0xCAFEF00D with wb_ack_o, ack 1 cycle after ready_i.
//  Back-to-back: 4 writes, master keeps cyc/stb up, IOb ready in 1st valid cycle
//   -> exactly 4 acks, 4 valid_o pulses, distinct addrs in order, issue-to-issue = 3 cycles.
//  Timeout: TIMEOUT=4, ready_i never -> valid_o high 4 cycles, then wb_err_o 1 cycle,
//   no ack; later stray ready_i ignored; next request completes normally.
//  Abort: master drops cyc_i 1 cycle after valid_o, ready_i 3 cycles later
//   -> valid_o held until ready_i, no ack/err, next request accepted.
//  Reset mid-REQ: rst_i 1 cycle while valid_o=1 -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/iob_wishbone2iob_if.sv
// Bus bundle for the Wishbone-slave / IOb-master bridge.
// slave: bridge view; master: Wishbone master plus IOb responder view.
interface iob_wishbone2iob_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   wb_addr_i;
    logic [DATA_W-1:0]   wb_data_i;
    logic [DATA_W/8-1:0] wb_select_i;
    logic                wb_we_i;
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic [DATA_W-1:0]   wb_data_o;
    logic                wb_ack_o;
    logic                wb_err_o;
    logic                valid_o;
    logic [ADDR_W-1:0]   address_o;
    logic [DATA_W-1:0]   wdata_o;
    logic [DATA_W/8-1:0] wstrb_o;
    logic [DATA_W-1:0]   rdata_i;
    logic                ready_i;

    modport slave (
        input  wb_addr_i, wb_data_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  rdata_i, ready_i,
        output wb_data_o, wb_ack_o, wb_err_o, valid_o, address_o, wdata_o, wstrb_o
    );

    modport master (
        output wb_addr_i, wb_data_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output rdata_i, ready_i,
        input  wb_data_o, wb_ack_o, wb_err_o, valid_o, address_o, wdata_o, wstrb_o
    );
endinterface

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb native master bridge: registers each request,
// holds it on IOb until ready_i, returns a one-cycle ack (or err on timeout).
module iob_wishbone2iob #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    iob_wishbone2iob_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, ACK, ERR, DRAIN} state_t;

    localparam bit                 TO_EN   = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W/8-1:0]  wstrb_q, wstrb_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic                 start;
    logic                 expire;
    logic [TIMEOUT_W-1:0] cnt_inc;

    assign start   = bus.wb_cyc_i & bus.wb_stb_i;
    assign expire  = TO_EN && (cnt_q == TO_LAST);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = bus.wb_addr_i;
                    wdata_d = bus.wb_data_i;
                    wstrb_d = bus.wb_we_i ? bus.wb_select_i : '0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.ready_i) begin
                    valid_d = 1'b0;
                    if (wstrb_q == '0) rdata_d = bus.rdata_i;
                    if (start) begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!bus.wb_cyc_i) begin
                    // Abort coinciding with expiry ends the drain immediately.
                    if (expire) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = DRAIN;
                    end
                end else if (expire) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DRAIN: begin
                if (bus.ready_i || expire) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_o   = valid_q;
    assign bus.address_o = addr_q;
    assign bus.wdata_o   = wdata_q;
    assign bus.wstrb_o   = wstrb_q;
    assign bus.wb_data_o = rdata_q;
    assign bus.wb_ack_o  = ack_q;
    assign bus.wb_err_o  = err_q;
endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Bench for iob_wishbone2iob: directed scenarios plus random transactions
// checked against a word-memory reference model.
module tb_iob_wishbone2iob;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    iob_wishbone2iob_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    iob_wishbone2iob #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TIMEOUT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] iob_mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic drop_master();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w);
        bus.wb_addr_i   = a;
        bus.wb_data_i   = d;
        bus.wb_select_i = s;
        bus.wb_we_i     = w;
        bus.wb_cyc_i    = 1'b1;
        bus.wb_stb_i    = 1'b1;
    endtask

    // IOb side: a read returns iob_mem, a write merges into it.
    task automatic iob_respond();
        int unsigned idx = int'(bus.address_o[5:2]);
        if (bus.wstrb_o == 4'h0) bus.rdata_i = iob_mem[idx];
        else iob_mem[idx] = merge(iob_mem[idx], bus.wdata_o, bus.wstrb_o);
        bus.ready_i = 1'b1;
    endtask

    // One Wishbone transaction; IOb answers dly cycles after valid_o (timeout if dly >= TO).
    task automatic wb_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, input int dly);
        logic [3:0] exp_strb = w ? s : 4'h0;
        drive_req(a, d, s, w);
        tick();
        check_eq("issue_valid", bus.valid_o, 1);
        check_eq("issue_addr", bus.address_o, a);
        check_eq("issue_wdata", bus.wdata_o, d);
        check_eq("issue_wstrb", bus.wstrb_o, exp_strb);
        check_eq("issue_noack", bus.wb_ack_o, 0);
        for (int k = 0; k < TO; k++) begin
            if (k > 0) begin
                check_eq("hold_valid", bus.valid_o, 1);
                check_eq("hold_addr", bus.address_o, a);
                check_eq("hold_wstrb", bus.wstrb_o, exp_strb);
            end
            if (k == dly) begin
                iob_respond();
                tick();
                bus.ready_i = 1'b0;
                bus.rdata_i = '0;
                if (w) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
                else exp_rd = ref_mem[a[5:2]];
                check_eq("ack", bus.wb_ack_o, 1);
                check_eq("ack_noerr", bus.wb_err_o, 0);
                check_eq("ack_valid_low", bus.valid_o, 0);
                check_eq("ack_rdata", bus.wb_data_o, exp_rd);
                drop_master();
                tick();
                check_eq("ack_pulse", bus.wb_ack_o, 0);
                check_eq("post_ack_valid", bus.valid_o, 0);
                return;
            end
            if (k == TO - 1) begin
                tick();
                check_eq("to_valid_low", bus.valid_o, 0);
                check_eq("to_err", bus.wb_err_o, 1);
                check_eq("to_noack", bus.wb_ack_o, 0);
                drop_master();
                tick();
                check_eq("err_pulse", bus.wb_err_o, 0);
                check_eq("post_err_valid", bus.valid_o, 0);
                return;
            end
            tick();
        end
    endtask

    // Read request abandoned by the master right after issue; IOb answers rdly cycles after valid_o.
    task automatic abort_txn(input logic [31:0] a, input int rdly);
        drive_req(a, 32'h0, 4'hF, 1'b0);
        tick();
        check_eq("abort_issue", bus.valid_o, 1);
        drop_master();
        for (int k = 0; k < TO; k++) begin
            if (k > 0) check_eq("drain_valid", bus.valid_o, 1);
            if (k == rdly || k == TO - 1) begin
                if (k == rdly) iob_respond();
                tick();
                bus.ready_i = 1'b0;
                bus.rdata_i = '0;
                check_eq("drain_valid_low", bus.valid_o, 0);
                check_eq("drain_noack", bus.wb_ack_o, 0);
                check_eq("drain_noerr", bus.wb_err_o, 0);
                check_eq("drain_rdata_kept", bus.wb_data_o, exp_rd);
                tick();
                check_eq("drain_idle", bus.valid_o, 0);
                return;
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];
        int acks, vpulses, last_issue;
        logic prev_valid;

        drop_master();
        bus.wb_addr_i   = '0;
        bus.wb_data_i   = '0;
        bus.wb_select_i = '0;
        bus.ready_i     = 1'b0;
        bus.rdata_i     = '0;
        for (int i = 0; i < 16; i++) begin
            iob_mem[i] = $urandom;
            ref_mem[i] = iob_mem[i];
        end
        iob_mem[8] = 32'hCAFEF00D;
        ref_mem[8] = 32'hCAFEF00D;

        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", bus.valid_o, 0);
        check_eq("rst_ack", bus.wb_ack_o, 0);
        check_eq("rst_err", bus.wb_err_o, 0);
        check_eq("rst_addr", bus.address_o, 0);
        check_eq("rst_wdata", bus.wdata_o, 0);
        check_eq("rst_wstrb", bus.wstrb_o, 0);
        check_eq("rst_rdata", bus.wb_data_o, 0);
        rst = 1'b0;
        tick();

        wb_txn(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 2);
        wb_txn(32'h20, 32'h0, 4'h3, 1'b0, 1);
        check_eq("read_cafef00d", bus.wb_data_o, 32'hCAFEF00D);

        // Back-to-back writes with cyc/stb held high throughout.
        for (int i = 0; i < 4; i++) begin
            b2b_addr[i] = 32'h4 * (i + 1);
            b2b_data[i] = $urandom;
        end
        acks = 0; vpulses = 0; last_issue = -1; prev_valid = 1'b0;
        drive_req(b2b_addr[0], b2b_data[0], 4'hF, 1'b1);
        for (int c = 0; c < 30 && acks < 4; c++) begin
            tick();
            check_eq("b2b_ack_err_excl", bus.wb_ack_o & bus.wb_err_o, 0);
            if (bus.valid_o && !prev_valid) begin
                vpulses++;
                check_eq("b2b_addr_order", bus.address_o, b2b_addr[(vpulses - 1) % 4]);
                if (last_issue >= 0) check_eq("b2b_issue_gap", c - last_issue, 3);
                last_issue = c;
            end
            prev_valid = bus.valid_o;
            if (bus.wb_ack_o) begin
                ref_mem[b2b_addr[acks][5:2]] = b2b_data[acks];
                acks++;
                if (acks < 4) drive_req(b2b_addr[acks], b2b_data[acks], 4'hF, 1'b1);
                else drop_master();
            end
            if (bus.valid_o) iob_respond();
            else bus.ready_i = 1'b0;
        end
        bus.ready_i = 1'b0;
        check_eq("b2b_acks", acks, 4);
        check_eq("b2b_valid_pulses", vpulses, 4);
        tick();

        // Timeout, then late ready must be ignored, then a normal transfer.
        wb_txn(32'h30, 32'h12345678, 4'hF, 1'b1, 99);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stray_ready_valid", bus.valid_o, 0);
            check_eq("stray_ready_ack", bus.wb_ack_o, 0);
        end
        bus.ready_i = 1'b0;
        wb_txn(32'h30, 32'h0, 4'hF, 1'b0, 0);

        abort_txn(32'h8, 3);
        wb_txn(32'h8, 32'h0, 4'hF, 1'b0, 1);
        abort_txn(32'hC, 99);
        wb_txn(32'hC, 32'h0, 4'hF, 1'b0, 0);

        // Reset while a request is outstanding.
        drive_req(32'h14, 32'hA5A5A5A5, 4'hF, 1'b1);
        tick();
        check_eq("midrst_issue", bus.valid_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drop_master();
        exp_rd = '0;
        check_eq("midrst_valid", bus.valid_o, 0);
        check_eq("midrst_addr", bus.address_o, 0);
        check_eq("midrst_wdata", bus.wdata_o, 0);
        check_eq("midrst_wstrb", bus.wstrb_o, 0);
        check_eq("midrst_rdata", bus.wb_data_o, 0);
        tick();
        check_eq("midrst_idle", bus.valid_o, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            int dly = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
            wb_txn(a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), dly);
            if ($urandom_range(0, 2) == 0) tick();
        end
        for (int i = 0; i < 16; i++) wb_txn(32'(i * 4), 32'h0, 4'hF, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
